// File: rtl/draw_scheduler.sv
// Frame draw scheduler: erase pass, inc_enable, draw pass over ball/bricks/platform.
// Owns the single VGA plot port and forwards the selected client's pixels.
module draw_scheduler #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int CW      = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            frame_tick,
    input  logic [2:0]      en_mask,
    output logic [2:0]      go,
    input  logic [2:0]      done,
    input  logic [2:0]      c_plot,
    input  logic [3*XW-1:0] c_x,
    input  logic [3*YW-1:0] c_y,
    input  logic [3*CW-1:0] c_colour,
    output logic [XW-1:0]   x,
    output logic [YW-1:0]   y,
    output logic [CW-1:0]   colour,
    output logic            plot,
    output logic            inc_enable,
    output logic            busy,
    output logic            frame_done,
    output logic            overrun,
    output logic            timeout
);

    localparam int CNTW = $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        UPDATE
    } state_t;

    state_t          state, state_n;
    logic            pass, pass_n;
    logic [1:0]      sel, sel_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            fdone_n, tmo_n, adv;
    logic            in_wait;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pass       <= 1'b0;
            sel        <= 2'd0;
            cnt        <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            pass       <= pass_n;
            sel        <= sel_n;
            cnt        <= cnt_n;
            frame_done <= fdone_n;
            overrun    <= frame_tick && (state != IDLE);
            timeout    <= tmo_n;
        end
    end

    always_comb begin
        state_n = state;
        pass_n  = pass;
        sel_n   = sel;
        cnt_n   = cnt;
        fdone_n = 1'b0;
        tmo_n   = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_n = LOAD;
                    pass_n  = 1'b0;
                    sel_n   = 2'd0;
                end
            end
            LOAD: begin
                if (en_mask[sel]) begin
                    cnt_n   = '0;
                    state_n = WAIT;
                end else begin
                    adv = 1'b1;
                end
            end
            WAIT: begin
                if (done[sel]) begin
                    adv = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    tmo_n = 1'b1;
                    adv   = 1'b1;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            UPDATE: begin
                pass_n  = 1'b1;
                sel_n   = 2'd0;
                state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
        // Shared end-of-client step for both the skip and the finished paths
        if (adv) begin
            if (sel != 2'd2) begin
                sel_n   = sel + 2'd1;
                state_n = LOAD;
            end else if (!pass) begin
                state_n = UPDATE;
            end else begin
                fdone_n = 1'b1;
                state_n = IDLE;
            end
        end
    end

    assign in_wait    = (state == WAIT);
    assign busy       = (state != IDLE);
    assign inc_enable = (state == UPDATE);

    always_comb begin
        go = 3'b000;
        if (state == LOAD) begin
            go = en_mask & (3'b001 << sel);
        end
    end

    always_comb begin
        plot   = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;
        if (in_wait) begin
            plot = c_plot[sel];
            x    = c_x[int'(sel)*XW +: XW];
            y    = c_y[int'(sel)*YW +: YW];
            if (pass) begin
                colour = c_colour[int'(sel)*CW +: CW];
            end
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: frame-trace model, emulated clients, directed scenarios.
// Model expands each accepted frame_tick into the expected per-cycle output trace.
module tb_draw_scheduler;

    localparam int XW = 10;
    localparam int YW = 10;
    localparam int CW = 3;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            frame_tick = 1'b0;
    logic [2:0]      en_mask = 3'b000;
    logic [2:0]      go;
    logic [2:0]      done;
    logic [2:0]      c_plot;
    logic [3*XW-1:0] c_x;
    logic [3*YW-1:0] c_y;
    logic [3*CW-1:0] c_colour;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot, inc_enable, busy, frame_done, overrun, timeout;

    always #5 clk = ~clk;

    draw_scheduler #(.XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .en_mask(en_mask), .go(go), .done(done), .c_plot(c_plot),
        .c_x(c_x), .c_y(c_y), .c_colour(c_colour),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .inc_enable(inc_enable), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .timeout(timeout)
    );

    int cmp_n = 0;
    int err_n = 0;

    // Client latency: done on WAIT cycle lat (1-based); 0 = never done
    int         lat [3];
    logic [9:0] bx  [3] = '{10'd100, 10'd200, 10'd300};
    logic [9:0] by  [3] = '{10'd10, 10'd20, 10'd30};
    logic [2:0] col [3] = '{3'b100, 3'b100, 3'b100};
    bit         act [3];
    int         cj  [3];

    initial begin
        logic [2:0] g;
        done = '0;
        c_plot = '0;
        c_x = '0;
        c_y = '0;
        c_colour = '0;
        forever begin
            @(negedge clk);
            g = go;
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!resetn) begin
                    act[i] = 1'b0;
                end else if (g[i]) begin
                    act[i] = 1'b1;
                    cj[i] = 0;
                end else if (act[i]) begin
                    if (lat[i] != 0 && cj[i] == lat[i] - 1) act[i] = 1'b0;
                    else cj[i]++;
                end
                c_plot[i] = 1'b1;
                if (act[i]) begin
                    done[i] = (lat[i] != 0 && cj[i] == lat[i] - 1);
                    c_x[i*XW +: XW] = bx[i] + 10'(cj[i]);
                    c_y[i*YW +: YW] = by[i] + 10'(cj[i]);
                    c_colour[i*CW +: CW] = col[i];
                end else begin
                    done[i] = 1'b1;
                    c_x[i*XW +: XW] = 10'h3C5;
                    c_y[i*YW +: YW] = 10'h2A7;
                    c_colour[i*CW +: CW] = 3'b111;
                end
            end
        end
    end

    typedef struct packed {
        logic [2:0] go;
        logic       plot;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
        logic       inc;
        logic       busy;
        logic       fd;
        logic       tmo;
    } rec_t;

    rec_t q[$];
    bit   pend = 1'b0;
    bit   ovr_p = 1'b0;

    task automatic push(input rec_t r);
        r.tmo = pend;
        pend = 1'b0;
        q.push_back(r);
    endtask

    task automatic gen_frame();
        rec_t r;
        int n;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) begin
                r = '0;
                r.busy = 1'b1;
                r.go = en_mask[i] ? 3'(1 << i) : 3'b000;
                push(r);
                if (en_mask[i]) begin
                    n = (lat[i] == 0 || lat[i] > TO) ? TO : lat[i];
                    for (int j = 0; j < n; j++) begin
                        r = '0;
                        r.busy = 1'b1;
                        r.plot = 1'b1;
                        r.x = bx[i] + 10'(j);
                        r.y = by[i] + 10'(j);
                        r.c = (p == 1) ? col[i] : 3'b000;
                        push(r);
                    end
                    if (lat[i] == 0 || lat[i] > TO) pend = 1'b1;
                end
            end
            if (p == 0) begin
                r = '0;
                r.busy = 1'b1;
                r.inc = 1'b1;
                push(r);
            end
        end
        r = '0;
        r.fd = 1'b1;
        push(r);
    endtask

    int n_go [3] = '{0, 0, 0};
    int n_inc = 0, n_fd = 0, n_tmo = 0, n_ovr = 0, n_busy = 0;
    int n_p0 = 0, n_p4 = 0;
    int cyc = 0;

    always @(negedge clk) begin
        rec_t e;
        logic [31:0] ev, av;
        logic eo;
        cyc++;
        if (!resetn) begin
            e = '0;
            q.delete();
            pend = 1'b0;
            ovr_p = 1'b0;
        end else begin
            e = (q.size() > 0) ? q.pop_front() : '0;
        end
        eo = resetn ? ovr_p : 1'b0;
        ev = {e.go, e.plot, e.x, e.y, e.c, e.inc, e.busy, e.fd, eo, e.tmo};
        av = {go, plot, x, y, colour, inc_enable, busy, frame_done, overrun, timeout};
        cmp_n++;
        if (av !== ev) begin
            err_n++;
            $display("FAIL cycle%0d outputs: got %h expected %h", cyc, av, ev);
        end
        for (int i = 0; i < 3; i++) n_go[i] += int'(go[i]);
        n_inc += int'(inc_enable);
        n_fd += int'(frame_done);
        n_tmo += int'(timeout);
        n_ovr += int'(overrun);
        n_busy += int'(busy);
        n_p0 += int'(plot && colour == 3'b000);
        n_p4 += int'(plot && colour == 3'b100);
        if (resetn) begin
            ovr_p = frame_tick && e.busy;
            if (frame_tick && !e.busy) gen_frame();
        end
    end

    int b_go [3];
    int b_inc, b_fd, b_tmo, b_ovr, b_busy, b_p0, b_p4;

    task automatic snap();
        for (int i = 0; i < 3; i++) b_go[i] = n_go[i];
        b_inc = n_inc;
        b_fd = n_fd;
        b_tmo = n_tmo;
        b_ovr = n_ovr;
        b_busy = n_busy;
        b_p0 = n_p0;
        b_p4 = n_p4;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        cmp_n++;
        if (got != exp) begin
            err_n++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (frame_done) break;
            k++;
        end
        chk({name, "_bounded"}, int'(k < 300), 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        lat = '{5, 5, 5};
        #12 frame_tick = 1'b1;
        #10 frame_tick = 1'b0;
        #1 chk("t1_outs_in_reset",
               int'({go, plot, inc_enable, busy, frame_done, overrun, timeout}), 0);
        @(negedge clk);
        #1 resetn = 1'b1;
        snap();
        repeat (5) @(negedge clk);
        #1;
        chk("t1_go_after_release", n_go[0] + n_go[1] + n_go[2] - b_go[0] - b_go[1] - b_go[2], 0);
        chk("t1_busy_after_release", n_busy - b_busy, 0);

        en_mask = 3'b111;
        snap();
        tick();
        wait_done("t2");
        chk("t2_busy_cycles", n_busy - b_busy, 37);
        chk("t2_go_ball", n_go[0] - b_go[0], 2);
        chk("t2_go_brick", n_go[1] - b_go[1], 2);
        chk("t2_go_plat", n_go[2] - b_go[2], 2);
        chk("t2_inc", n_inc - b_inc, 1);
        chk("t2_frame_done", n_fd - b_fd, 1);
        chk("t2_black_pixels", n_p0 - b_p0, 15);
        chk("t2_colour_pixels", n_p4 - b_p4, 15);

        en_mask = 3'b101;
        lat = '{1, 1, 1};
        snap();
        tick();
        wait_done("t3");
        chk("t3_busy_cycles", n_busy - b_busy, 11);
        chk("t3_go_brick", n_go[1] - b_go[1], 0);
        chk("t3_go_plat", n_go[2] - b_go[2], 2);

        en_mask = 3'b111;
        lat = '{2, 2, 0};
        snap();
        tick();
        wait_done("t4");
        chk("t4_timeouts", n_tmo - b_tmo, 2);
        chk("t4_busy_cycles", n_busy - b_busy, 31);
        chk("t4_frame_done", n_fd - b_fd, 1);

        lat = '{5, 5, 5};
        snap();
        tick();
        tick();
        wait_done("t5");
        chk("t5_overrun", n_ovr - b_ovr, 1);
        chk("t5_busy_cycles", n_busy - b_busy, 37);
        chk("t5_inc", n_inc - b_inc, 1);

        en_mask = 3'b000;
        snap();
        tick();
        wait_done("t7");
        chk("t7_busy_cycles", n_busy - b_busy, 7);
        chk("t7_inc", n_inc - b_inc, 1);
        chk("t7_go", n_go[0] + n_go[1] + n_go[2] - b_go[0] - b_go[1] - b_go[2], 0);

        en_mask = 3'b111;
        tick();
        repeat (21) @(posedge clk);
        #3;
        chk("t6_plot_before_reset", int'(plot), 1);
        chk("t6_colour_before_reset", int'(colour), 4);
        resetn = 1'b0;
        #1;
        chk("t6_plot_in_reset", int'(plot), 0);
        chk("t6_busy_in_reset", int'(busy), 0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        snap();
        repeat (10) @(negedge clk);
        #1;
        chk("t6_inc_after", n_inc - b_inc, 0);
        chk("t6_go_after", n_go[0] + n_go[1] + n_go[2] - b_go[0] - b_go[1] - b_go[2], 0);
        chk("t6_busy_after", n_busy - b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
